// File: rtl/fp_degree_div.sv
// Iterative FP16 divide by an unsigned integer degree: out_value = in_value / in_degree.
// Restoring division yields one quotient bit per clock; results round away from zero when inexact.
module fp_degree_div #(
    parameter int DEG_W = 16,
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_value,
    input  logic [DEG_W-1:0] in_degree,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_value,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LZ_W = $clog2(DEG_W);

    typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;

    state_t state, state_next;

    logic             op_sign;
    logic [4:0]       op_exp;
    logic [9:0]       op_man;
    logic [DEG_W-1:0] op_degree;
    logic [TAG_W-1:0] op_tag;
    logic [DEG_W-1:0] divisor;
    logic [LZ_W-1:0]  shift_k;
    logic [DEG_W:0]   remainder;
    logic [11:0]      quotient;
    logic [3:0]       div_count;

    logic             accept;
    logic             bypass;
    logic [15:0]      bypass_value;
    logic [LZ_W-1:0]  lz;
    logic [DEG_W-1:0] d_norm;
    logic [LZ_W-1:0]  k;
    logic             ge;
    logic [DEG_W:0]   diff;
    logic [9:0]       mant;
    logic             adj;
    logic             round_up;
    logic [10:0]      mant_sum;
    logic signed [7:0] exp_calc;
    logic [15:0]      round_value;

    assign accept = in_valid && in_ready;

    // Operands that need no division complete straight from IDLE; priority order matters.
    always_comb begin
        bypass       = 1'b1;
        bypass_value = {in_value[15], 15'h0};
        if (in_degree == '0) begin
            bypass_value = {in_value[15], 15'h0};
        end else if (in_value[14:10] == 5'h1F) begin
            bypass_value = in_value;
        end else if (in_value[14:10] == 5'h00) begin
            bypass_value = {in_value[15], 15'h0};
        end else begin
            bypass = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = bypass ? DONE : NORM;
            end
            NORM:  state_next = DIV;
            DIV:   if (div_count == 4'd11) state_next = ROUND;
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Highest set bit wins, giving floor(log2(degree)) as k.
    always_comb begin
        lz = '0;
        for (int i = 0; i < DEG_W; i++) begin
            if (op_degree[i]) lz = LZ_W'(DEG_W - 1 - i);
        end
    end

    assign d_norm = op_degree << lz;
    assign k      = LZ_W'(DEG_W - 1) - lz;
    assign ge     = remainder >= {1'b0, divisor};
    assign diff   = remainder - {1'b0, divisor};

    // Quotient below 1.0 is renormalised; its shifted-in bit is zero so only sticky rounds it.
    always_comb begin
        adj         = ~quotient[11];
        mant        = quotient[11] ? quotient[10:1] : quotient[9:0];
        round_up    = (quotient[11] & quotient[0]) | (remainder != '0);
        mant_sum    = {1'b0, mant} + 11'(round_up);
        exp_calc    = 8'(op_exp) - 8'(shift_k) - 8'(adj);
        if (mant_sum[10]) exp_calc = exp_calc + 8'sd1;
        round_value = {op_sign, exp_calc[4:0], mant_sum[9:0]};
        if (exp_calc <= 0) begin
            round_value = {op_sign, 15'h0};
        end else if (exp_calc >= 31) begin
            round_value = {op_sign, 5'h1F, 10'h0};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_sign   <= 1'b0;
            op_exp    <= '0;
            op_man    <= '0;
            op_degree <= '0;
            op_tag    <= '0;
            divisor   <= '0;
            shift_k   <= '0;
            remainder <= '0;
            quotient  <= '0;
            div_count <= '0;
            out_value <= '0;
            out_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_sign   <= in_value[15];
                        op_exp    <= in_value[14:10];
                        op_man    <= in_value[9:0];
                        op_degree <= in_degree;
                        op_tag    <= in_tag;
                        if (bypass) begin
                            out_value <= bypass_value;
                            out_tag   <= in_tag;
                        end
                    end
                end
                NORM: begin
                    // Dividend and divisor share the same binary point at bit DEG_W-1.
                    divisor   <= d_norm;
                    shift_k   <= k;
                    remainder <= {1'b0, 1'b1, op_man, {(DEG_W - 11){1'b0}}};
                    quotient  <= '0;
                    div_count <= '0;
                end
                DIV: begin
                    quotient  <= {quotient[10:0], ge};
                    remainder <= (ge ? diff : remainder) << 1;
                    div_count <= div_count + 4'd1;
                end
                ROUND: begin
                    out_value <= round_value;
                    out_tag   <= op_tag;
                end
                default: ;
            endcase
        end
    end

endmodule
